// File: rtl/lsu_bus_ctrl.sv
// Sequential load/store unit: one EXU operation at a time over a req/gnt/rvalid bus,
// with lane steering, load extension, misalignment, bus-error and grant-timeout faults.
module lsu_bus_ctrl #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                n_rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [3:0]          op_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [4:0]          rd_addr_i,
  input  logic [31:0]         pc_i,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [XLEN/8-1:0]   bus_be_o,
  output logic [XLEN-1:0]     bus_wdata_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [XLEN-1:0]     bus_rdata_i,
  input  logic                bus_err_i,
  output logic                rsp_valid_o,
  output logic                rd_we_o,
  output logic [4:0]          rd_addr_o,
  output logic [XLEN-1:0]     rd_wdata_o,
  output logic                exc_valid_o,
  output logic [3:0]          exc_cause_o,
  output logic [ADDR_W-1:0]   exc_tval_o,
  output logic [31:0]         exc_pc_o
);
  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_addr_q;
  logic [31:0]       pc_q;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              exc_q, exc_d;
  logic [3:0]        cause_q, cause_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic              accept, misaligned, tmo_hit, in_resp;
  logic [OW-1:0]     off;
  logic [BW-1:0]     be_mask;
  logic [XLEN-1:0]   rsh, rext;

  assign accept  = req_valid_i && (state_q == IDLE);
  assign off     = addr_q[OW-1:0];
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
  assign rsh     = bus_rdata_i >> {off, 3'b000};

  always_comb begin
    case (op_i[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_i[0];
      2'd2:    misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = (XLEN == 32) || (addr_i[2:0] != 3'b000);
    endcase
  end

  always_comb begin
    case (op_q[1:0])
      2'd0:    be_mask = BW'(1);
      2'd1:    be_mask = BW'(3);
      2'd2:    be_mask = BW'(15);
      default: be_mask = '1;
    endcase
  end

  // Size casts of $signed operands sign-extend; unsigned loads take the plain cast.
  always_comb begin
    case (op_q[1:0])
      2'd0:    rext = op_q[2] ? XLEN'(rsh[7:0])  : XLEN'($signed(rsh[7:0]));
      2'd1:    rext = op_q[2] ? XLEN'(rsh[15:0]) : XLEN'($signed(rsh[15:0]));
      2'd2:    rext = op_q[2] ? XLEN'(rsh[31:0]) : XLEN'($signed(rsh[31:0]));
      default: rext = rsh;
    endcase
  end

  // Cause encoding is {2'b01, we, fault}: 4/5 load, 6/7 store.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    exc_d   = exc_q;
    cause_d = cause_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          exc_d   = misaligned;
          cause_d = misaligned ? {2'b01, op_i[3], 1'b0} : '0;
          rdata_d = '0;
          state_d = misaligned ? RESP : REQ;
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          state_d = WAIT;
          tmo_d   = '0;
        end else if (tmo_hit) begin
          state_d = RESP;
          tmo_d   = '0;
          exc_d   = 1'b1;
          cause_d = {2'b01, op_q[3], 1'b1};
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          state_d = RESP;
          if (bus_err_i) begin
            exc_d   = 1'b1;
            cause_d = {2'b01, op_q[3], 1'b1};
          end else if (!op_q[3]) begin
            rdata_d = rext;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      exc_q     <= 1'b0;
      cause_q   <= '0;
      rdata_q   <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_addr_q <= '0;
      pc_q      <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
      if (accept) begin
        op_q      <= op_i;
        addr_q    <= addr_i;
        wdata_q   <= wdata_i;
        rd_addr_q <= rd_addr_i;
        pc_q      <= pc_i;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = bus_req_o && op_q[3];
  assign bus_addr_o  = bus_req_o ? {addr_q[ADDR_W-1:OW], {OW{1'b0}}} : '0;
  assign bus_be_o    = bus_req_o ? (be_mask << off) : '0;
  assign bus_wdata_o = bus_we_o ? (wdata_q << {off, 3'b000}) : '0;

  assign in_resp     = (state_q == RESP);
  assign rsp_valid_o = in_resp;
  assign rd_we_o     = in_resp && !op_q[3] && !exc_q;
  assign rd_addr_o   = in_resp ? rd_addr_q : '0;
  assign rd_wdata_o  = in_resp ? rdata_q : '0;
  assign exc_valid_o = in_resp && exc_q;
  assign exc_cause_o = exc_valid_o ? cause_q : '0;
  assign exc_tval_o  = exc_valid_o ? addr_q : '0;
  assign exc_pc_o    = exc_valid_o ? pc_q : '0;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: XLEN=32/TIMEOUT=4 main instance, XLEN=64 instance for wide loads.
module tb_lsu_bus_ctrl;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req_valid_i, req_ready_o;
  logic [3:0]  op_i;
  logic [31:0] addr_i, wdata_i, pc_i;
  logic [4:0]  rd_addr_i;
  logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;
  logic        rsp_valid_o, rd_we_o, exc_valid_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o, exc_tval_o, exc_pc_o;
  logic [3:0]  exc_cause_o;

  logic        w_req_valid, w_req_ready, w_bus_req, w_bus_we, w_gnt, w_rvalid, w_err;
  logic [3:0]  w_op, w_cause;
  logic [31:0] w_addr, w_bus_addr, w_tval, w_pc;
  logic [63:0] w_wdata, w_bus_wdata, w_rdata, w_rd_wdata;
  logic [7:0]  w_be;
  logic        w_rsp_valid, w_rd_we, w_exc_valid;
  logic [4:0]  w_rd_addr;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TMO)) u_dut (
    .clk_i(clk), .n_rst_i(n_rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i), .pc_i(pc_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i), .rsp_valid_o(rsp_valid_o),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o),
    .exc_pc_o(exc_pc_o)
  );

  lsu_bus_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT(8)) u_dut64 (
    .clk_i(clk), .n_rst_i(n_rst), .req_valid_i(w_req_valid), .req_ready_o(w_req_ready),
    .op_i(w_op), .addr_i(w_addr), .wdata_i(w_wdata), .rd_addr_i(5'd9), .pc_i(32'h900),
    .bus_req_o(w_bus_req), .bus_we_o(w_bus_we), .bus_addr_o(w_bus_addr), .bus_be_o(w_be),
    .bus_wdata_o(w_bus_wdata), .bus_gnt_i(w_gnt), .bus_rvalid_i(w_rvalid),
    .bus_rdata_i(w_rdata), .bus_err_i(w_err), .rsp_valid_o(w_rsp_valid),
    .rd_we_o(w_rd_we), .rd_addr_o(w_rd_addr), .rd_wdata_o(w_rd_wdata),
    .exc_valid_o(w_exc_valid), .exc_cause_o(w_cause), .exc_tval_o(w_tval), .exc_pc_o(w_pc)
  );

  typedef struct {
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] tval;
    logic [31:0] pc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        exp_e;
  logic        ok;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] b_addr, b_wd;
  logic [3:0]  b_be;
  logic        b_we, stable, ready_after, rsp_again;
  int          req_cycles, rsp_lat;

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (n_rst && rsp_valid_o) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got response pc=%h cause=%0d, required no response", exc_pc_o, exc_cause_o);
      end else begin
        exp_e = sbq.pop_front();
        if (exp_e.exc)
          ok = (exc_valid_o === 1'b1) && (exc_cause_o === exp_e.cause) && (exc_tval_o === exp_e.tval)
               && (exc_pc_o === exp_e.pc) && (rd_we_o === 1'b0);
        else
          ok = (exc_valid_o === 1'b0) && (rd_we_o === exp_e.rd_we) && (rd_wdata_o === exp_e.wd)
               && (!exp_e.rd_we || (rd_addr_o === exp_e.rd));
        if (!ok) begin
          errors++;
          $display("FAIL rsp_fields: got we=%b rd=%0d wd=%h exc=%b cause=%0d tval=%h pc=%h, required we=%b rd=%0d wd=%h exc=%b cause=%0d tval=%h pc=%h",
                   rd_we_o, rd_addr_o, rd_wdata_o, exc_valid_o, exc_cause_o, exc_tval_o, exc_pc_o,
                   exp_e.rd_we, exp_e.rd, exp_e.wd, exp_e.exc, exp_e.cause, exp_e.tval, exp_e.pc);
        end
      end
    end
  end

  // Issues one op and acts as the bus: grant after gdly REQ cycles, rvalid the cycle after grant.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rdat,
                       input logic err, input int gdly);
    int   k;
    logic granted, done;
    k = 0; granted = 1'b0; done = 1'b0;
    req_cycles = 0; rsp_lat = 0; stable = 1'b1;
    req_valid_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd; rd_addr_i = rd; pc_i = pc;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
      if (c == 0) begin
        req_valid_i = 1'b0;
        b_addr = bus_addr_o; b_be = bus_be_o; b_wd = bus_wdata_o; b_we = bus_we_o;
      end else if (bus_req_o && ({bus_addr_o, bus_be_o, bus_wdata_o, bus_we_o} !== {b_addr, b_be, b_wd, b_we})) begin
        stable = 1'b0;
      end
      if (rsp_valid_o) begin
        rsp_lat = c + 1;
        done = 1'b1;
      end else if (bus_req_o) begin
        req_cycles++;
        if (k == gdly) begin
          bus_gnt_i = 1'b1;
          granted = 1'b1;
        end
        k++;
      end else if (granted) begin
        bus_rvalid_i = 1'b1; bus_rdata_i = rdat; bus_err_i = err; granted = 1'b0;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rsp_wait: got no rsp_valid_o within 40 cycles for pc=%h, required one", pc);
    end
    @(negedge clk);
    ready_after = req_ready_o;
    rsp_again = rsp_valid_o;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    req_valid_i = 0; op_i = 0; addr_i = 0; wdata_i = 0; rd_addr_i = 0; pc_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; bus_err_i = 0;
    w_req_valid = 0; w_op = 0; w_addr = 0; w_wdata = 0; w_gnt = 0; w_rvalid = 0; w_rdata = 0; w_err = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, rsp_valid_o, rd_we_o, rd_addr_o,
         rd_wdata_o, exc_valid_o, exc_cause_o, exc_tval_o, exc_pc_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got bus_req=%b be=%b rsp=%b exc=%b, required all zero", bus_req_o, bus_be_o, rsp_valid_o, exc_valid_o);
    end
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got req_ready_o=%b, required 1", req_ready_o);
    end
  endtask

  task automatic test_load_byte;
    sbq.push_back('{1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 4'd0, 32'h0, 32'h100});
    do_op(4'b0000, 32'h1003, 32'h0, 5'd5, 32'h100, 32'h80FF_1234, 1'b0, 0);
    checks++;
    if ({b_addr, b_be, b_we} !== {32'h1000, 4'b1000, 1'b0}) begin
      errors++;
      $display("FAIL lb_bus: got addr=%h be=%b we=%b, required addr=00001000 be=1000 we=0", b_addr, b_be, b_we);
    end
    checks++;
    if (rsp_lat != 3 || req_cycles != 1) begin
      errors++;
      $display("FAIL lb_latency: got rsp at %0d req cycles %0d, required 3 and 1", rsp_lat, req_cycles);
    end
    checks++;
    if (rsp_again !== 1'b0 || ready_after !== 1'b1) begin
      errors++;
      $display("FAIL lb_pulse: got rsp_valid=%b ready=%b after pulse, required 0 and 1", rsp_again, ready_after);
    end
  endtask

  task automatic test_store;
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h110});
    do_op(4'b1001, 32'h2002, 32'h0000_ABCD, 5'd7, 32'h110, 32'h0, 1'b0, 2);
    checks++;
    if ({b_addr, b_be, b_wd, b_we} !== {32'h2000, 4'b1100, 32'hABCD_0000, 1'b1}) begin
      errors++;
      $display("FAIL sh_bus: got addr=%h be=%b wdata=%h we=%b, required 00002000 1100 abcd0000 1", b_addr, b_be, b_wd, b_we);
    end
    checks++;
    if (stable !== 1'b1 || req_cycles != 3) begin
      errors++;
      $display("FAIL sh_hold: got stable=%b req cycles %0d, required 1 and 3", stable, req_cycles);
    end
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h114});
    do_op(4'b1000, 32'h2001, 32'h0000_0012, 5'd7, 32'h114, 32'h0, 1'b0, 0);
    checks++;
    if ({b_be, b_wd} !== {4'b0010, 32'h0000_1200}) begin
      errors++;
      $display("FAIL sb_bus: got be=%b wdata=%h, required 0010 00001200", b_be, b_wd);
    end
  endtask

  task automatic test_misaligned;
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 4'd4, 32'h3001, 32'h120});
    do_op(4'b0010, 32'h3001, 32'h0, 5'd3, 32'h120, 32'h0, 1'b0, 0);
    checks++;
    if (rsp_lat != 1 || req_cycles != 0) begin
      errors++;
      $display("FAIL lw_mis: got rsp at %0d req cycles %0d, required 1 and 0", rsp_lat, req_cycles);
    end
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 4'd6, 32'h3005, 32'h124});
    do_op(4'b1001, 32'h3005, 32'h1, 5'd3, 32'h124, 32'h0, 1'b0, 0);
    checks++;
    if (req_cycles != 0) begin
      errors++;
      $display("FAIL sh_mis: got req cycles %0d, required 0", req_cycles);
    end
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 4'd4, 32'h0008, 32'h128});
    do_op(4'b0011, 32'h0008, 32'h0, 5'd3, 32'h128, 32'h0, 1'b0, 0);
    checks++;
    if (req_cycles != 0) begin
      errors++;
      $display("FAIL ld_on_32: got req cycles %0d, required 0", req_cycles);
    end
  endtask

  task automatic test_timeout;
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 4'd5, 32'h0040, 32'h130});
    do_op(4'b0010, 32'h0040, 32'h0, 5'd4, 32'h130, 32'h0, 1'b0, 100);
    checks++;
    if (req_cycles != TMO || rsp_lat != TMO + 1) begin
      errors++;
      $display("FAIL tmo_load: got req cycles %0d rsp at %0d, required %0d and %0d", req_cycles, rsp_lat, TMO, TMO + 1);
    end
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 4'd7, 32'h0044, 32'h134});
    do_op(4'b1010, 32'h0044, 32'h5, 5'd4, 32'h134, 32'h0, 1'b0, 100);
    checks++;
    if (req_cycles != TMO) begin
      errors++;
      $display("FAIL tmo_store: got req cycles %0d, required %0d", req_cycles, TMO);
    end
    // grant lands in the final REQ cycle and must beat the timeout
    sbq.push_back('{1'b1, 5'd6, 32'h0000_00A5, 1'b0, 4'd0, 32'h0, 32'h138});
    do_op(4'b0100, 32'h0048, 32'h0, 5'd6, 32'h138, 32'h0000_00A5, 1'b0, TMO - 1);
    checks++;
    if (req_cycles != TMO || rsp_lat != TMO + 2) begin
      errors++;
      $display("FAIL tmo_gnt_wins: got req cycles %0d rsp at %0d, required %0d and %0d", req_cycles, rsp_lat, TMO, TMO + 2);
    end
  endtask

  task automatic test_bus_error;
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 4'd5, 32'h0006, 32'h140});
    do_op(4'b0101, 32'h0006, 32'h0, 5'd8, 32'h140, 32'hFFFF_FFFF, 1'b1, 0);
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 4'd7, 32'h0008, 32'h144});
    do_op(4'b1010, 32'h0008, 32'h1234_5678, 5'd8, 32'h144, 32'h0, 1'b1, 1);
  endtask

  task automatic test_load_ext;
    for (int n = 0; n < 12; n++) begin
      int          sz, nb, off;
      logic        uns;
      logic [31:0] rdat, v;
      logic [3:0]  ebe;
      sz = $urandom_range(0, 2);
      nb = 1 << sz;
      off = $urandom_range(0, 3) & ~(nb - 1);
      uns = 1'($urandom_range(0, 1));
      rdat = $urandom;
      v = '0;
      ebe = '0;
      for (int i = 0; i < nb; i++) begin
        v[8*i +: 8] = rdat[8*(off+i) +: 8];
        ebe[off+i] = 1'b1;
      end
      if (!uns && v[8*nb-1])
        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
      sbq.push_back('{1'b1, 5'(n + 10), v, 1'b0, 4'd0, 32'h0, 32'h200 + 32'(n)});
      do_op({1'b0, uns, 2'(sz)}, 32'h4000 + 32'(off), 32'h0, 5'(n + 10), 32'h200 + 32'(n), rdat, 1'b0, $urandom_range(0, 2));
      checks++;
      if ({b_be, b_addr} !== {ebe, 32'h4000}) begin
        errors++;
        $display("FAIL ext_bus_%0d: got be=%b addr=%h, required be=%b addr=00004000", n, b_be, b_addr, ebe);
      end
    end
  endtask

  task automatic test_back_to_back;
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 4'd4, 32'h1001, 32'h300});
    req_valid_i = 1'b1; op_i = 4'b0001; addr_i = 32'h1001; pc_i = 32'h300;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_resp1: got req_ready_o=%b, required 0", req_ready_o);
    end
    sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 4'd6, 32'h2002, 32'h304});
    op_i = 4'b1010; addr_i = 32'h2002; pc_i = 32'h304;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_idle: got req_ready_o=%b, required 1", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_resp2: got req_ready_o=%b, required 0", req_ready_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    req_valid_i = 1'b1; op_i = 4'b0010; addr_i = 32'h0050; pc_i = 32'h400; rd_addr_i = 5'd2;
    @(negedge clk);
    req_valid_i = 1'b0;
    checks++;
    if (bus_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req: got bus_req_o=%b, required 1", bus_req_o);
    end
    bus_gnt_i = 1'b1;
    @(negedge clk);
    bus_gnt_i = 1'b0;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({bus_req_o, bus_be_o, rsp_valid_o, rd_we_o, exc_valid_o, req_ready_o} !== {1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_outputs: got bus_req=%b be=%b rsp=%b ready=%b, required 0 0000 0 1", bus_req_o, bus_be_o, rsp_valid_o, req_ready_o);
    end
    @(negedge clk);
    n_rst = 1'b1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_rvalid_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || bus_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stray: got rsp=%b ready=%b bus_req=%b, required 0 1 0", rsp_valid_o, req_ready_o, bus_req_o);
    end
    @(negedge clk);
  endtask

  task automatic test_xlen64;
    logic [3:0]  ops [3];
    logic [31:0] adrs[3];
    logic [63:0] rds [3];
    logic [63:0] exps[3];
    logic [7:0]  bes [3];
    ops[0] = 4'b0011; adrs[0] = 32'h8; rds[0] = 64'hFEDC_BA98_7654_3210; exps[0] = 64'hFEDC_BA98_7654_3210; bes[0] = 8'hFF;
    ops[1] = 4'b0010; adrs[1] = 32'hC; rds[1] = 64'h8000_0001_1234_5678; exps[1] = 64'hFFFF_FFFF_8000_0001; bes[1] = 8'hF0;
    ops[2] = 4'b0110; adrs[2] = 32'hC; rds[2] = 64'h8000_0001_1234_5678; exps[2] = 64'h0000_0000_8000_0001; bes[2] = 8'hF0;
    for (int n = 0; n < 3; n++) begin
      w_req_valid = 1'b1; w_op = ops[n]; w_addr = adrs[n];
      @(negedge clk);
      w_req_valid = 1'b0;
      checks++;
      if ({w_bus_req, w_be, w_bus_addr} !== {1'b1, bes[n], 32'h8}) begin
        errors++;
        $display("FAIL x64_bus_%0d: got req=%b be=%h addr=%h, required 1 %h 00000008", n, w_bus_req, w_be, w_bus_addr, bes[n]);
      end
      w_gnt = 1'b1;
      @(negedge clk);
      w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = rds[n];
      @(negedge clk);
      w_rvalid = 1'b0;
      checks++;
      if ({w_rsp_valid, w_rd_we, w_exc_valid, w_rd_wdata} !== {1'b1, 1'b1, 1'b0, exps[n]}) begin
        errors++;
        $display("FAIL x64_rsp_%0d: got rsp=%b we=%b exc=%b data=%h, required 1 1 0 %h", n, w_rsp_valid, w_rd_we, w_exc_valid, w_rd_wdata, exps[n]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store();
    test_misaligned();
    test_timeout();
    test_bus_error();
    test_load_ext();
    test_back_to_back();
    test_reset_mid();
    test_xlen64();
    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding responses, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
